fft_ctrl_gen: RTL and testbench
===============================

FFT_CTRL_GEN -- requirements
Module: fft_ctrl_gen

Interface
REQ-001 SHALL have parameter LOG2N, default 6, log2 of FFT points N (N=2^LOG2N, LOG2N 3..12).
REQ-002 SHALL have parameter RD_LAT, default 1, memory read latency in cycles.
REQ-003 SHALL have parameter BF_LAT, default 2, butterfly latency in cycles; W=RD_LAT+BF_LAT is the write delay.
REQ-004 SHALL have parameter BITREV_OUT, default 1: 1 = natural-order unload, 0 = raw index order.
REQ-005 clk input 1 -- single clock, rising edge.
REQ-006 rst input 1 -- asynchronous, active-high reset.
REQ-007 start input 1 -- frame request pulse; in_valid input 1 -- input sample present.
REQ-008 in_ready output 1; busy output 1; done output 1 -- one-cycle end-of-frame pulse.
REQ-009 we_b0, we_b1, re_b0, re_b1 output 1 -- bank strobes; waddr_b0, waddr_b1, raddr_b0, raddr_b1 output LOG2N-1 -- bank addresses.
REQ-010 in_bank_sel output 1; bf_swap_rd output 1; bf_swap_wr output 1; tw_idx output LOG2N-1; stage output clog2(LOG2N).
REQ-011 out_valid output 1; out_bank_sel output 1; out_idx output LOG2N.

Function
REQ-012 Element index x SHALL map to bank parity(x) (XOR of all bits of x), at address x[LOG2N-1:1].
REQ-013 The FSM SHALL have the states IDLE, LOAD, COMPUTE, DRAIN, UNLOAD, and done SHALL pulse on the last UNLOAD cycle.
REQ-014 IDLE: start SHALL move the FSM to LOAD, busy SHALL be 0, and a start in any other state SHALL be ignored.
REQ-015 LOAD: in_ready SHALL be 1, and an accepted sample number c SHALL produce we_b(parity(c))=1, waddr=c>>1 and in_bank_sel=parity(c), all combinationally in the same cycle.
REQ-016 LOAD: c SHALL increment only on in_valid, gaps SHALL stall, and sample N-1 SHALL take the FSM to COMPUTE with stage=0 and k=0.
REQ-017 COMPUTE: butterfly counter k SHALL run 0..N/2-1, one pair per cycle, and re_b0=re_b1=1.
REQ-018 With p=LOG2N-1-stage, the pair SHALL be a = k with a 0 inserted at bit p and b = a | (1<<p).
REQ-019 The parity-0 element of the pair SHALL go to raddr_b0 and the other to raddr_b1, with bf_swap_rd=parity(a).
REQ-020 tw_idx SHALL equal (k mod 2^p) << stage.
REQ-021 we_b0/we_b1, waddr_b0/waddr_b1 and bf_swap_wr SHALL be the read-side values delayed exactly W cycles through a shift pipeline.
REQ-022 After k=N/2-1 the FSM SHALL enter DRAIN for W cycles with no reads, so no stage overlaps the previous stage's writes.
REQ-023 After DRAIN, stage SHALL increment and return to COMPUTE; after the DRAIN of stage LOG2N-1 it SHALL go to UNLOAD.
REQ-024 UNLOAD: j SHALL run 0..N-1, reading x=bitrev(j) (BITREV_OUT=1) or x=j (BITREV_OUT=0) from bank parity(x) at address x>>1.
REQ-025 out_valid, out_idx=j and out_bank_sel SHALL appear RD_LAT cycles after the corresponding read.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 After the UNLOAD pipeline empties, done SHALL pulse and the FSM SHALL return to IDLE.
REQ-028 Only one of LOAD writes, COMPUTE delayed writes or UNLOAD reads SHALL drive the bank ports in any cycle.
REQ-029 All counters SHALL be unsigned, and k, c and j SHALL reset to 0 on each state entry with no wrap beyond their terminal values.

Reset
REQ-030 rst SHALL force, asynchronously: state IDLE, all counters 0, all delay pipelines cleared.
REQ-031 On rst, every output SHALL be 0.
REQ-032 rst asserted mid-frame SHALL abort the frame with no done pulse and no further we_b0/we_b1 write, including in-flight delayed writes.

Verification (LOG2N=6, RD_LAT=1, BF_LAT=2, W=3)
REQ-033 Load with gaps: samples 3 and 7 -> sample 3 gives we_b0=1, waddr_b0=1; sample 7 gives we_b1=1, waddr_b1=3; COMPUTE entered only after the 64th in_valid.
REQ-034 Stage 0 reads: k=0 -> raddr_b0=0, raddr_b1=16, swap 0, tw 0; k=1 -> raddr_b0=16, raddr_b1=0, swap 1, tw 1; write of k=1 appears 3 cycles later with bf_swap_wr=1.
REQ-035 Stage 5: k=4 -> a=8, b=9, raddr_b1=4, raddr_b0=4, swap 1, tw_idx=0; 3-cycle DRAIN precedes UNLOAD; compute spans 6*(32+3)=210 cycles.
REQ-036 Unload BITREV_OUT=1: j=1 -> x=32 read from bank1 addr 16; out_valid with out_idx=1 one cycle later; done after out_idx=63; second start while busy ignored.
REQ-037 rst pulse at stage 2, k=10 -> all outputs 0 immediately, no done pulse; next start gives a clean full frame.

Source files
------------

// File: rtl/fft_ctrl_gen.sv
// fft_ctrl_gen: address/strobe sequencer for an in-place radix-2 FFT over two
// memory banks. Element x lives in bank parity(x) at address x>>1, so both
// members of every butterfly pair always sit in opposite banks.
module fft_ctrl_gen #(
  parameter int LOG2N      = 6,
  parameter int RD_LAT     = 1,
  parameter int BF_LAT     = 2,
  parameter int BITREV_OUT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      we_b0,
  output logic                      we_b1,
  output logic                      re_b0,
  output logic                      re_b1,
  output logic [LOG2N-2:0]          waddr_b0,
  output logic [LOG2N-2:0]          waddr_b1,
  output logic [LOG2N-2:0]          raddr_b0,
  output logic [LOG2N-2:0]          raddr_b1,
  output logic                      in_bank_sel,
  output logic                      bf_swap_rd,
  output logic                      bf_swap_wr,
  output logic [LOG2N-2:0]          tw_idx,
  output logic [$clog2(LOG2N)-1:0]  stage,
  output logic                      out_valid,
  output logic                      out_bank_sel,
  output logic [LOG2N-1:0]          out_idx
);

  localparam int AW  = LOG2N - 1;
  localparam int SW  = $clog2(LOG2N);
  localparam int N   = 1 << LOG2N;
  localparam int W   = RD_LAT + BF_LAT;
  localparam int DW  = $clog2(W + 1);
  localparam int WPW = 2 * AW + 2;   // valid, addr0, addr1, swap
  localparam int OPW = LOG2N + 2;    // valid, idx, bank

  localparam logic [LOG2N-1:0] C_MAX  = '1;
  localparam logic [AW-1:0]    K_MAX  = '1;
  localparam logic [DW-1:0]    D_MAX  = DW'(W - 1);
  localparam logic [SW-1:0]    S_LAST = SW'(LOG2N - 1);
  localparam logic [LOG2N:0]   U_N    = (LOG2N + 1)'(N);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_UNLOAD} state_t;

  state_t           state_reg, state_next;
  logic [LOG2N-1:0] c_reg;
  logic [AW-1:0]    k_reg;
  logic [DW-1:0]    d_reg;
  logic [SW-1:0]    stage_reg;
  logic [LOG2N:0]   u_reg;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  // Butterfly pair: k with a zero spliced in at bit p gives a; b sets that bit.
  logic [SW-1:0]    p_val;
  logic [LOG2N-1:0] lo_mask, kx, pair_a, pair_b;
  logic [AW-1:0]    tw_mask, tw_val, rd0, rd1;
  logic             par_a;

  assign p_val   = S_LAST - stage_reg;
  assign lo_mask = (LOG2N'(1) << p_val) - LOG2N'(1);
  assign kx      = {1'b0, k_reg};
  assign pair_a  = ((kx & ~lo_mask) << 1) | (kx & lo_mask);
  assign pair_b  = pair_a | (LOG2N'(1) << p_val);
  assign par_a   = ^pair_a;
  assign rd0     = par_a ? AW'(pair_b >> 1) : AW'(pair_a >> 1);
  assign rd1     = par_a ? AW'(pair_a >> 1) : AW'(pair_b >> 1);
  // When p = LOG2N-1 the shift overflows to 0 and the mask becomes all ones.
  assign tw_mask = (AW'(1) << p_val) - AW'(1);
  assign tw_val  = (k_reg & tw_mask) << stage_reg;

  // Unload read side
  logic [LOG2N-1:0] u_idx, un_x;
  logic             un_rd, par_x;

  assign u_idx = u_reg[LOG2N-1:0];
  assign un_x  = (BITREV_OUT != 0) ? bitrev(u_idx) : u_idx;
  assign par_x = ^un_x;
  assign un_rd = (state_reg == S_UNLOAD) && (u_reg < U_N);

  // Delay pipelines: butterfly writes trail reads by W, unload data by RD_LAT.
  logic [WPW-1:0] wpipe_in;
  logic [WPW-1:0] wpipe_reg [W];
  logic [OPW-1:0] opipe_in;
  logic [OPW-1:0] opipe_reg [RD_LAT];

  assign wpipe_in = (state_reg == S_COMPUTE) ? {1'b1, rd0, rd1, par_a} : '0;
  assign opipe_in = un_rd ? {1'b1, u_idx, par_x} : '0;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_wpipe
      // Shift stage of the delayed-write pipeline
      always_ff @(posedge clk or posedge rst) begin
        if (rst) wpipe_reg[gi] <= '0;
        else if (gi == 0) wpipe_reg[gi] <= wpipe_in;
        else wpipe_reg[gi] <= wpipe_reg[(gi == 0) ? 0 : gi - 1];
      end
    end
    for (gi = 0; gi < RD_LAT; gi++) begin : g_opipe
      // Shift stage of the unload read-latency pipeline
      always_ff @(posedge clk or posedge rst) begin
        if (rst) opipe_reg[gi] <= '0;
        else if (gi == 0) opipe_reg[gi] <= opipe_in;
        else opipe_reg[gi] <= opipe_reg[(gi == 0) ? 0 : gi - 1];
      end
    end
  endgenerate

  logic [WPW-1:0] wp_out;
  logic [OPW-1:0] op_out;
  logic           done_w;

  assign wp_out = wpipe_reg[W-1];
  assign op_out = opipe_reg[RD_LAT-1];
  assign done_w = (state_reg == S_UNLOAD) && op_out[OPW-1] && (op_out[LOG2N:1] == C_MAX);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Frame counters; each restarts from 0 when its phase is entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_reg     <= '0;
      k_reg     <= '0;
      d_reg     <= '0;
      stage_reg <= '0;
      u_reg     <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          c_reg     <= '0;
          k_reg     <= '0;
          d_reg     <= '0;
          stage_reg <= '0;
          u_reg     <= '0;
        end
        S_LOAD: begin
          if (in_valid) c_reg <= (c_reg == C_MAX) ? '0 : c_reg + LOG2N'(1);
        end
        S_COMPUTE: begin
          k_reg <= (k_reg == K_MAX) ? '0 : k_reg + AW'(1);
          d_reg <= '0;
        end
        S_DRAIN: begin
          if (d_reg == D_MAX) begin
            d_reg <= '0;
            if (stage_reg != S_LAST) stage_reg <= stage_reg + SW'(1);
          end else begin
            d_reg <= d_reg + DW'(1);
          end
        end
        S_UNLOAD: begin
          if (u_reg < U_N) u_reg <= u_reg + (LOG2N + 1)'(1);
        end
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (start) state_next = S_LOAD;
      S_LOAD:    if (in_valid && c_reg == C_MAX) state_next = S_COMPUTE;
      S_COMPUTE: if (k_reg == K_MAX) state_next = S_DRAIN;
      S_DRAIN:   if (d_reg == D_MAX) state_next = (stage_reg == S_LAST) ? S_UNLOAD : S_COMPUTE;
      S_UNLOAD:  if (done_w) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Output decode; bank ports are owned by exactly one phase at a time
  always_comb begin
    in_ready     = 1'b0;
    busy         = (state_reg != S_IDLE);
    done         = done_w;
    we_b0        = 1'b0;
    we_b1        = 1'b0;
    re_b0        = 1'b0;
    re_b1        = 1'b0;
    waddr_b0     = '0;
    waddr_b1     = '0;
    raddr_b0     = '0;
    raddr_b1     = '0;
    in_bank_sel  = 1'b0;
    bf_swap_rd   = 1'b0;
    bf_swap_wr   = 1'b0;
    tw_idx       = '0;
    stage        = '0;
    out_valid    = op_out[OPW-1];
    out_idx      = op_out[LOG2N:1];
    out_bank_sel = op_out[0];
    case (state_reg)
      S_LOAD: begin
        in_ready    = 1'b1;
        in_bank_sel = ^c_reg;
        if (in_valid) begin
          if (^c_reg) begin
            we_b1    = 1'b1;
            waddr_b1 = AW'(c_reg >> 1);
          end else begin
            we_b0    = 1'b1;
            waddr_b0 = AW'(c_reg >> 1);
          end
        end
      end
      S_COMPUTE, S_DRAIN: begin
        stage      = stage_reg;
        we_b0      = wp_out[WPW-1];
        we_b1      = wp_out[WPW-1];
        waddr_b0   = wp_out[2*AW:AW+1];
        waddr_b1   = wp_out[AW:1];
        bf_swap_wr = wp_out[0];
        if (state_reg == S_COMPUTE) begin
          re_b0      = 1'b1;
          re_b1      = 1'b1;
          raddr_b0   = rd0;
          raddr_b1   = rd1;
          bf_swap_rd = par_a;
          tw_idx     = tw_val;
        end
      end
      S_UNLOAD: begin
        if (un_rd) begin
          if (par_x) begin
            re_b1    = 1'b1;
            raddr_b1 = AW'(un_x >> 1);
          end else begin
            re_b0    = 1'b1;
            raddr_b0 = AW'(un_x >> 1);
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fft_ctrl_gen.sv
// Bench for fft_ctrl_gen at LOG2N=6, RD_LAT=1, BF_LAT=2: cycle-stamped
// expectations are queued by the stimulus and matched by a negedge monitor.
module tb_fft_ctrl_gen;
  localparam int LOG2N = 6;
  localparam int N     = 64;

  logic       clk = 1'b0;
  logic       rst, start, in_valid;
  logic       in_ready, busy, done, we_b0, we_b1, re_b0, re_b1;
  logic [4:0] waddr_b0, waddr_b1, raddr_b0, raddr_b1, tw_idx;
  logic       in_bank_sel, bf_swap_rd, bf_swap_wr, out_valid, out_bank_sel;
  logic [2:0] stage;
  logic [5:0] out_idx;

  fft_ctrl_gen #(.LOG2N(6), .RD_LAT(1), .BF_LAT(2), .BITREV_OUT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .busy(busy), .done(done),
    .we_b0(we_b0), .we_b1(we_b1), .re_b0(re_b0), .re_b1(re_b1),
    .waddr_b0(waddr_b0), .waddr_b1(waddr_b1), .raddr_b0(raddr_b0), .raddr_b1(raddr_b1),
    .in_bank_sel(in_bank_sel), .bf_swap_rd(bf_swap_rd), .bf_swap_wr(bf_swap_wr),
    .tw_idx(tw_idx), .stage(stage),
    .out_valid(out_valid), .out_bank_sel(out_bank_sel), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int v0; int v1; int v2; int v3; int v4; } rec_t;
  rec_t lq[$], rq[$], wq[$], uq[$], oq[$], dq[$];
  int n_cmp = 0;
  int n_fail = 0;

  logic [57:0] all_out;
  assign all_out = {in_ready, busy, done, we_b0, we_b1, re_b0, re_b1, waddr_b0, waddr_b1,
                    raddr_b0, raddr_b1, in_bank_sel, bf_swap_rd, bf_swap_wr, tw_idx, stage,
                    out_valid, out_bank_sel, out_idx};

  function automatic int par(input int x);
    int r = 0;
    for (int i = 0; i < 32; i++) r ^= (x >> i) & 1;
    return r;
  endfunction

  function automatic int brev(input int x);
    int r = 0;
    for (int i = 0; i < LOG2N; i++) if (((x >> i) & 1) != 0) r |= 1 << (LOG2N - 1 - i);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cmp_rec(input string nm, input bit have, input rec_t e, input rec_t a);
    n_cmp++;
    if (!have) begin
      n_fail++;
      $display("FAIL %s: unexpected event cyc=%0d v=%0d,%0d,%0d,%0d,%0d, none expected",
               nm, a.cyc, a.v0, a.v1, a.v2, a.v3, a.v4);
    end else if (e != a) begin
      n_fail++;
      $display("FAIL %s: got cyc=%0d v=%0d,%0d,%0d,%0d,%0d expected cyc=%0d v=%0d,%0d,%0d,%0d,%0d",
               nm, a.cyc, a.v0, a.v1, a.v2, a.v3, a.v4, e.cyc, e.v0, e.v1, e.v2, e.v3, e.v4);
    end else begin
      $display("ok %s cyc=%0d v=%0d,%0d,%0d,%0d,%0d", nm, a.cyc, a.v0, a.v1, a.v2, a.v3, a.v4);
    end
  endtask

  // Monitor: every observed bank/output event is matched against the queues
  always @(negedge clk) begin : mon
    rec_t a;
    rec_t e;
    if (!rst) begin
      if (we_b0 ^ we_b1) begin
        a = '{cyc, int'(we_b1), we_b1 ? int'(waddr_b1) : int'(waddr_b0), int'(in_bank_sel), 0, 0};
        if (lq.size() > 0) begin e = lq.pop_front(); cmp_rec("load_write", 1, e, a); end
        else cmp_rec("load_write", 0, a, a);
      end
      if (we_b0 & we_b1) begin
        a = '{cyc, int'(waddr_b0), int'(waddr_b1), int'(bf_swap_wr), 0, 0};
        if (wq.size() > 0) begin e = wq.pop_front(); cmp_rec("bf_write", 1, e, a); end
        else cmp_rec("bf_write", 0, a, a);
      end
      if (re_b0 & re_b1) begin
        a = '{cyc, int'(raddr_b0), int'(raddr_b1), int'(bf_swap_rd), int'(tw_idx), int'(stage)};
        if (rq.size() > 0) begin e = rq.pop_front(); cmp_rec("bf_read", 1, e, a); end
        else cmp_rec("bf_read", 0, a, a);
      end
      if (re_b0 ^ re_b1) begin
        a = '{cyc, int'(re_b1), re_b1 ? int'(raddr_b1) : int'(raddr_b0), 0, 0, 0};
        if (uq.size() > 0) begin e = uq.pop_front(); cmp_rec("unload_read", 1, e, a); end
        else cmp_rec("unload_read", 0, a, a);
      end
      if (out_valid) begin
        a = '{cyc, int'(out_idx), int'(out_bank_sel), 0, 0, 0};
        if (oq.size() > 0) begin e = oq.pop_front(); cmp_rec("out", 1, e, a); end
        else cmp_rec("out", 0, a, a);
      end
      if (done) begin
        a = '{cyc, 0, 0, 0, 0, 0};
        if (dq.size() > 0) begin e = dq.pop_front(); cmp_rec("done", 1, e, a); end
        else cmp_rec("done", 0, a, a);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Return at the negedge of cycle t
  task automatic wait_cycle(input int t);
    @(negedge clk);
    while (cyc < t) @(negedge clk);
    if (cyc != t) chk("schedule", cyc, t);
  endtask

  task automatic clear_queues();
    lq.delete(); rq.delete(); wq.delete(); uq.delete(); oq.delete(); dq.delete();
  endtask

  task automatic push_model(input int x);
    int p, a, b, pa;
    for (int s = 0; s < LOG2N; s++) begin
      p = LOG2N - 1 - s;
      for (int k = 0; k < N / 2; k++) begin
        a  = ((k >> p) << (p + 1)) | (k % (1 << p));
        b  = a + (1 << p);
        pa = par(a);
        rq.push_back('{x + 1 + 35 * s + k, pa ? b / 2 : a / 2, pa ? a / 2 : b / 2, pa,
                       ((k % (1 << p)) << s) % 32, s});
        wq.push_back('{x + 4 + 35 * s + k, pa ? b / 2 : a / 2, pa ? a / 2 : b / 2, pa, 0, 0});
      end
    end
    for (int j = 0; j < N; j++) begin
      uq.push_back('{x + 211 + j, par(brev(j)), brev(j) / 2, 0, 0, 0});
      oq.push_back('{x + 212 + j, j, par(brev(j)), 0, 0, 0});
    end
    dq.push_back('{x + 275, 0, 0, 0, 0, 0});
  endtask

  task automatic run_frame(input bit abort);
    int x;
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    @(negedge clk);
    chk("load_busy_ready", {busy, in_ready}, 2'b11);
    for (int c = 0; c < N; c++) begin
      if (c % 5 == 2) begin tick(); in_valid = 1'b0; end
      tick(); in_valid = 1'b1;
      lq.push_back('{cyc, par(c), c >> 1, par(c), 0, 0});
      if (c == 3) begin
        @(negedge clk);
        chk("s3_we_b0", we_b0, 1); chk("s3_waddr_b0", waddr_b0, 1);
      end
      if (c == 7) begin
        @(negedge clk);
        chk("s7_we_b1", we_b1, 1); chk("s7_waddr_b1", waddr_b1, 3);
      end
      if (c == 62) begin
        @(negedge clk);
        chk("still_load_at_62", in_ready, 1);
      end
    end
    x = cyc;
    push_model(x);
    tick(); in_valid = 1'b0;
    wait_cycle(x + 1);
    chk("s0k0_raddr_b1", raddr_b1, 16); chk("s0k0_swap", bf_swap_rd, 0);
    wait_cycle(x + 2);
    chk("s0k1_raddr_b0", raddr_b0, 16); chk("s0k1_raddr_b1", raddr_b1, 0);
    chk("s0k1_swap", bf_swap_rd, 1); chk("s0k1_tw", tw_idx, 1);
    wait_cycle(x + 5);
    chk("s0k1_wr_we", {we_b0, we_b1}, 2'b11); chk("s0k1_wr_addr0", waddr_b0, 16);
    chk("s0k1_wr_swap", bf_swap_wr, 1);
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    if (abort) begin
      wait_cycle(x + 81);
      chk("s2k10_stage", stage, 2); chk("s2k10_tw", tw_idx, 8);
      chk("s2k10_raddr_b0", raddr_b0, 9); chk("s2k10_raddr_b1", raddr_b1, 13);
      #1 rst = 1'b1;
      #1 chk("abort_outputs_zero", $countones(all_out), 0);
      clear_queues();
      tick(); tick(); rst = 1'b0;
    end else begin
      wait_cycle(x + 180);
      chk("s5k4_raddr_b0", raddr_b0, 4); chk("s5k4_raddr_b1", raddr_b1, 4);
      chk("s5k4_swap", bf_swap_rd, 1); chk("s5k4_tw", tw_idx, 0); chk("s5k4_stage", stage, 5);
      wait_cycle(x + 208);
      chk("drain_no_read", {re_b0, re_b1}, 0); chk("drain_stage", stage, 5);
      wait_cycle(x + 212);
      chk("j1_re", {re_b0, re_b1}, 2'b01); chk("j1_raddr_b1", raddr_b1, 16);
      wait_cycle(x + 213);
      chk("j1_out_valid", out_valid, 1); chk("j1_out_idx", out_idx, 1);
      wait_cycle(x + 275);
      chk("done_pulse", done, 1); chk("done_idx", out_idx, 63);
      wait_cycle(x + 276);
      chk("idle_busy", busy, 0); chk("idle_done", done, 0);
      chk("q_empty", lq.size() + rq.size() + wq.size() + uq.size() + oq.size() + dq.size(), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("reset_outputs_zero", $countones(all_out), 0);
    tick(); rst = 1'b0;
    tick(); in_valid = 1'b1;
    @(negedge clk);
    chk("idle_ignores_valid", {busy, we_b0, we_b1}, 0);
    in_valid = 1'b0;
    run_frame(1'b0);
    repeat (5) tick();
    run_frame(1'b1);
    repeat (300) tick();
    @(negedge clk);
    chk("after_abort_idle", busy, 0);
    run_frame(1'b0);
    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
